// File: rtl/tri_pkg.sv
// Shared types and sizing for the triangle load controller.
// One triangle is NUM_WORDS serial words of WORD_W bits.
package tri_pkg;
    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 9;
    localparam int TIMEOUT   = 24;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int TMR_W     = $clog2(TIMEOUT);
    localparam int TRI_W     = NUM_WORDS * WORD_W;

    typedef logic [WORD_W-1:0] tri_word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FULL
    } state_t;
endpackage

// File: rtl/tri_out_reg.sv
// One-entry valid/ready holding register presenting a whole triangle.
// A load takes priority and may coincide with the handshake that empties it.
module tri_out_reg
    import tri_pkg::*;
#(
    parameter int W = TRI_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);
    logic         valid_reg;
    logic [W-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
endmodule

// File: rtl/tri_load_ctrl.sv
// Sequences the serial deserializer to capture one triangle of NUM_WORDS words,
// then hands the complete bank to the rasterizer through a valid/ready register.
module tri_load_ctrl
    import tri_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             link_start,
    input  logic             frame_sync,
    output logic             sipo_valid,
    input  logic             sipo_done,
    input  logic [WORD_W-1:0] sipo_word,
    output logic             tri_valid,
    input  logic             tri_ready,
    output logic [TRI_W-1:0] tri_data,
    output logic             busy,
    output logic             err_drop,
    output logic             err_timeout
);
    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [TMR_W-1:0] tmr_reg;
    tri_word_t        bank_reg [NUM_WORDS];
    logic             err_drop_reg;
    logic             err_timeout_reg;

    logic             last_word;
    logic             start_ok;
    logic             out_load;
    logic [TRI_W-1:0] bank_flat;

    assign last_word = (idx_reg == IDX_W'(NUM_WORDS - 1));

    // A start is only taken when the SIPO is free, or is freeing up this cycle
    // on a word that does not complete the bank.
    always_comb begin
        start_ok = 1'b0;
        if (frame_sync) begin
            start_ok = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE:  start_ok = 1'b1;
                S_WAIT:  start_ok = sipo_done && !last_word;
                default: start_ok = 1'b0;
            endcase
        end
    end

    assign sipo_valid = link_start && start_ok;
    assign out_load   = !frame_sync && (state_reg == S_FULL) && (!tri_valid || tri_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            tmr_reg         <= '0;
            err_drop_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                bank_reg[i] <= '0;
            end
        end else begin
            if (link_start && !start_ok) begin
                err_drop_reg <= 1'b1;
            end

            if (frame_sync) begin
                idx_reg   <= '0;
                tmr_reg   <= '0;
                state_reg <= link_start ? S_WAIT : S_IDLE;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (link_start) begin
                            tmr_reg   <= '0;
                            state_reg <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (sipo_done) begin
                            bank_reg[idx_reg] <= sipo_word;
                            tmr_reg           <= '0;
                            if (last_word) begin
                                state_reg <= S_FULL;
                            end else begin
                                idx_reg   <= idx_reg + IDX_W'(1);
                                // a coincident start has already restarted the SIPO
                                state_reg <= link_start ? S_WAIT : S_IDLE;
                            end
                        end else if (tmr_reg == TMR_W'(TIMEOUT - 1)) begin
                            err_timeout_reg <= 1'b1;
                            idx_reg         <= '0;
                            tmr_reg         <= '0;
                            state_reg       <= S_IDLE;
                        end else if (tmr_reg != '1) begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end
                    S_FULL: begin
                        if (out_load) begin
                            idx_reg   <= '0;
                            state_reg <= S_IDLE;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_flat
            assign bank_flat[gi*WORD_W +: WORD_W] = bank_reg[gi];
        end
    endgenerate

    tri_out_reg #(
        .W(TRI_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (out_load),
        .load_data (bank_flat),
        .ready     (tri_ready),
        .valid     (tri_valid),
        .data      (tri_data)
    );

    assign busy        = (state_reg != S_IDLE);
    assign err_drop    = err_drop_reg;
    assign err_timeout = err_timeout_reg;
endmodule
